// File: rtl/emu_dec_capture.sv
// emu_dec_capture: decimation strobe generator driving a counted probe capture into a FWFT FIFO
// Ports: emu_clk/emu_rst clock and async active-high reset; emu_dec_thr/emu_dec_cmp decimation
// threshold and strobe; arm/n_samples start a capture of n_samples slots; probe_in captured word;
// rd_data/rd_valid/rd_ready FIFO read side; busy/done/overflow capture status.
module emu_dec_capture #(
  parameter int dec_bits = 24,
  parameter int probe_bits = 32,
  parameter int depth = 16,
  parameter int cnt_bits = 16
)(
  input  logic                  emu_clk,
  input  logic                  emu_rst,
  input  logic [dec_bits-1:0]   emu_dec_thr,
  output logic                  emu_dec_cmp,
  input  logic                  arm,
  input  logic [cnt_bits-1:0]   n_samples,
  input  logic [probe_bits-1:0] probe_in,
  output logic [probe_bits-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam int aw = $clog2(depth);
  typedef enum logic [1:0] {s_idle, s_capture, s_drain, s_done} state_t;
  state_t state, state_nx;
  logic [dec_bits-1:0] dec_cnt;
  logic [cnt_bits-1:0] remaining;
  logic [aw:0] wptr, rptr;
  logic [probe_bits-1:0] mem [depth];
  logic empty, full, pop, slot, push, last, start;
  assign emu_dec_cmp = dec_cnt >= emu_dec_thr;
  assign empty = wptr == rptr;
  // extra pointer bit distinguishes full from empty when the index bits match
  assign full = (wptr ^ rptr) == {1'b1, {aw{1'b0}}};
  assign pop = !empty && rd_ready;
  assign slot = state == s_capture && emu_dec_cmp;
  // a pop in the same cycle frees the entry this push needs
  assign push = slot && (!full || pop);
  assign last = remaining == cnt_bits'(1);
  assign start = (state == s_idle || state == s_done) && arm;
  assign rd_valid = !empty;
  assign rd_data = mem[rptr[aw-1:0]];
  assign busy = state == s_capture || state == s_drain;
  assign done = state == s_done;
  always_ff @(posedge emu_clk or posedge emu_rst)
    if (emu_rst) dec_cnt <= '0;
    else dec_cnt <= emu_dec_cmp ? '0 : dec_cnt + dec_bits'(1);
  always_ff @(posedge emu_clk or posedge emu_rst)
    if (emu_rst) state <= s_idle;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = start ? (n_samples == '0 ? s_done : s_capture)
             : (slot && last) ? s_drain
             : (state == s_drain && empty) ? s_done
             : state;
  end
  always_ff @(posedge emu_clk or posedge emu_rst)
    if (emu_rst) begin
      remaining <= '0;
      overflow <= 1'b0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (start) begin
        remaining <= n_samples;
        overflow <= 1'b0;
      end else if (slot) begin
        remaining <= remaining - cnt_bits'(1);
        if (!push) overflow <= 1'b1;
      end
      if (push) wptr <= wptr + (aw+1)'(1);
      if (pop) rptr <= rptr + (aw+1)'(1);
    end
  always_ff @(posedge emu_clk)
    if (push) mem[wptr[aw-1:0]] <= probe_in;
endmodule
